// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing controller for the 1x3 router input side.
// Optional packet/drop counters are built when ROUTER_FSM_STATS_EN is defined.
module router_fsm_ctrl #(
  parameter int STATS_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pkt_valid,
  input  logic [1:0]         din,
  input  logic               fifofull,
  input  logic               e0,
  input  logic               e1,
  input  logic               e2,
  input  logic               srst0,
  input  logic               srst1,
  input  logic               srst2,
  input  logic               parity_done,
  input  logic               low_pkt_valid,
  output logic               detect_add,
  output logic               lfd_state,
  output logic               ld_state,
  output logic               laf_state,
  output logic               full_state,
  output logic               wr_en_reg,
  output logic               rst_int_reg,
  output logic               busy
`ifdef ROUTER_FSM_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_cnt,
  output logic [STATS_W-1:0] drop_cnt
`endif
);

  localparam logic [2:0] DA  = 3'd0;
  localparam logic [2:0] LFD = 3'd1;
  localparam logic [2:0] LD  = 3'd2;
  localparam logic [2:0] FFS = 3'd3;
  localparam logic [2:0] LAF = 3'd4;
  localparam logic [2:0] LP  = 3'd5;
  localparam logic [2:0] CPE = 3'd6;
  localparam logic [2:0] WTE = 3'd7;

  logic [2:0] state_q, state_d;
  logic [1:0] addr_q, addr_d;

  // Padded to four entries so that indexing with a 2-bit address never leaves the vector.
  logic [3:0] empty_vec;
  logic [3:0] srst_vec;
  logic       hdr_ok;
  logic       srst_sel;

  assign empty_vec = {1'b0, e2, e1, e0};
  assign srst_vec  = {1'b0, srst2, srst1, srst0};
  assign hdr_ok    = pkt_valid && (din != 2'd3);
  assign srst_sel  = srst_vec[addr_q] && (state_q != DA);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DA && hdr_ok) begin
      addr_d = din;
    end
    if (srst_sel) begin
      state_d = DA;
    end else begin
      case (state_q)
        DA:      if (hdr_ok) state_d = empty_vec[din] ? LFD : WTE;
        LFD:     state_d = LD;
        LD: begin
          if (fifofull)        state_d = FFS;
          else if (!pkt_valid) state_d = LP;
        end
        FFS:     if (!fifofull) state_d = LAF;
        LAF: begin
          if (parity_done)        state_d = DA;
          else if (low_pkt_valid) state_d = LP;
          else                    state_d = LD;
        end
        LP:      state_d = CPE;
        CPE:     state_d = fifofull ? FFS : DA;
        WTE:     if (empty_vec[addr_q]) state_d = LFD;
        default: state_d = DA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DA;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign detect_add  = (state_q == DA);
  assign lfd_state   = (state_q == LFD);
  assign ld_state    = (state_q == LD);
  assign laf_state   = (state_q == LAF);
  assign full_state  = (state_q == FFS);
  assign wr_en_reg   = (state_q == LFD) || (state_q == LD) || (state_q == LAF) || (state_q == LP);
  assign rst_int_reg = (state_q == CPE);
  assign busy        = !((state_q == DA) || (state_q == LD));

`ifdef ROUTER_FSM_STATS_EN
  logic [STATS_W-1:0] pkt_cnt_q;
  logic [STATS_W-1:0] drop_cnt_q;
  logic               pkt_done;
  logic               drop_hit;

  // A packet completes on the normal exit paths only; soft-reset aborts are not counted.
  assign pkt_done = !srst_sel &&
                    (((state_q == CPE) && !fifofull) || ((state_q == LAF) && parity_done));
  assign drop_hit = (state_q == DA) && pkt_valid && (din == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pkt_done && (pkt_cnt_q != '1)) begin
        pkt_cnt_q <= pkt_cnt_q + STATS_W'(1);
      end
      if (drop_hit && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + STATS_W'(1);
      end
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Bench for router_fsm_ctrl: directed scenarios plus randomized traffic against a packet-level model.
module tb_router_fsm_ctrl;

  localparam int SW      = 4;
  localparam int CNT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst, pkt_valid, fifofull, parity_done, low_pkt_valid;
  logic [1:0] din;
  logic [2:0] e, srst;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       wr_en_reg, rst_int_reg, busy;
`ifdef ROUTER_FSM_STATS_EN
  logic [SW-1:0] pkt_cnt, drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  router_fsm_ctrl #(.STATS_W(SW)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifofull(fifofull),
    .e0(e[0]), .e1(e[1]), .e2(e[2]),
    .srst0(srst[0]), .srst1(srst[1]), .srst2(srst[2]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .wr_en_reg(wr_en_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
`ifdef ROUTER_FSM_STATS_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  // Packet-phase reference model
  typedef enum {M_DA, M_LFD, M_LD, M_FFS, M_LAF, M_LP, M_CPE, M_WTE} mstate_t;
  mstate_t m_st;
  int      m_addr, m_pkt, m_drop;

  // Output table: {detect_add, lfd, ld, laf, full, wr_en, rst_int, busy}
  function automatic logic [7:0] exp_outs(mstate_t s);
    case (s)
      M_DA:    return 8'b1000_0000;
      M_LFD:   return 8'b0100_0101;
      M_LD:    return 8'b0010_0100;
      M_LAF:   return 8'b0001_0101;
      M_FFS:   return 8'b0000_1001;
      M_LP:    return 8'b0000_0101;
      M_CPE:   return 8'b0000_0011;
      default: return 8'b0000_0001;
    endcase
  endfunction

  function automatic logic [7:0] obs_v();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, wr_en_reg, rst_int_reg, busy};
  endfunction

  function automatic void model_reset();
    m_st = M_DA; m_addr = 0; m_pkt = 0; m_drop = 0;
  endfunction

  function automatic void model_step();
    mstate_t nx;
    if (rst) begin
      model_reset();
      return;
    end
    nx = m_st;
    if (m_st != M_DA && srst[m_addr]) nx = M_DA;
    else case (m_st)
      M_DA: begin
        if (pkt_valid && din == 2'd3 && m_drop < CNT_MAX) m_drop++;
        if (pkt_valid && din != 2'd3) begin
          m_addr = int'(din);
          nx = e[m_addr] ? M_LFD : M_WTE;
        end
      end
      M_LFD: nx = M_LD;
      M_LD:  if (fifofull) nx = M_FFS; else if (!pkt_valid) nx = M_LP;
      M_FFS: if (!fifofull) nx = M_LAF;
      M_LAF: begin
        if (parity_done) begin
          nx = M_DA;
          if (m_pkt < CNT_MAX) m_pkt++;
        end else if (low_pkt_valid) nx = M_LP;
        else nx = M_LD;
      end
      M_LP:  nx = M_CPE;
      M_CPE: begin
        if (fifofull) nx = M_FFS;
        else begin
          nx = M_DA;
          if (m_pkt < CNT_MAX) m_pkt++;
        end
      end
      M_WTE: if (e[m_addr]) nx = M_LFD;
      default: nx = M_DA;
    endcase
    m_st = nx;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; din = 0; fifofull = 0; e = 3'b111; srst = 0;
    parity_done = 0; low_pkt_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; model_reset();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [2:0] trio;
    n_checks++;
    if (obs_v() !== 8'b1000_0000) $display("FAIL reset_state: got %b want %b", obs_v(), 8'b1000_0000);
    else n_pass++;
    rst = 0;
    pkt_valid = 1; din = 2'd1;
    tick(); tick();
    n_checks++;
    if (obs_v() !== exp_outs(m_st) || !ld_state) $display("FAIL reset_reach_ld: got %b want %b", obs_v(), exp_outs(M_LD));
    else n_pass++;
    #2; rst = 1; model_reset(); #1;
    trio = {detect_add, busy, wr_en_reg};
    n_checks++;
    if (trio !== 3'b100) $display("FAIL reset_async_mid_ld: got %b want 100", trio);
    else n_pass++;
    idle_inputs();
    tick();
    rst = 0;
    tick();
    n_checks++;
    if (obs_v() !== 8'b1000_0000) $display("FAIL reset_release: got %b want %b", obs_v(), 8'b1000_0000);
    else n_pass++;
    $display("txn reset: mid-LD async reset done");
  endtask

  task automatic test_packet();
    int wr_cnt = 0;
    din = 2'd1; e = 3'b111;
    for (int c = 0; c < 9; c++) begin
      pkt_valid = (c < 6);
      tick();
      if (wr_en_reg) wr_cnt++;
      n_checks++;
      if (obs_v() !== exp_outs(m_st)) $display("FAIL packet_cycle%0d: got %b want %b", c, obs_v(), exp_outs(m_st));
      else n_pass++;
    end
    n_checks++;
    if (wr_cnt !== 7 || !detect_add) $display("FAIL packet_wr_cycles: got %0d (da=%b) want 7 (da=1)", wr_cnt, detect_add);
    else n_pass++;
    $display("txn packet: port1 6-cycle packet, wr_en cycles=%0d", wr_cnt);
  endtask

  task automatic test_wait_empty();
    int wte_cnt = 0;
    din = 2'd2; e = 3'b011; pkt_valid = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (obs_v() === 8'b0000_0001) wte_cnt++;
    end
    e = 3'b111;
    tick();
    n_checks++;
    if (wte_cnt !== 4 || !lfd_state) $display("FAIL wait_empty: got wte=%0d lfd=%b want wte=4 lfd=1", wte_cnt, lfd_state);
    else n_pass++;
    tick(); tick();
    pkt_valid = 0;
    for (int k = 0; k < 20 && !detect_add; k++) tick();
    n_checks++;
    if (obs_v() !== exp_outs(m_st) || !detect_add) $display("FAIL wait_empty_finish: got %b want %b", obs_v(), 8'b1000_0000);
    else n_pass++;
    $display("txn wait_empty: port2 waited %0d cycles", wte_cnt);
  endtask

  task automatic test_fifo_full();
    int full_cnt = 0, laf_cnt = 0, busy_bad = 0;
    din = 2'd0; e = 3'b111;
    for (int c = 0; c < 11; c++) begin
      pkt_valid = (c < 8);
      fifofull  = (c == 4 || c == 5);
      tick();
      if (full_state) full_cnt++;
      if (laf_state) laf_cnt++;
      if ((full_state || laf_state) && !busy) busy_bad++;
      n_checks++;
      if (obs_v() !== exp_outs(m_st)) $display("FAIL fifo_full_cycle%0d: got %b want %b", c, obs_v(), exp_outs(m_st));
      else n_pass++;
      if (c == 7) begin
        n_checks++;
        if (!ld_state) $display("FAIL fifo_full_back_to_ld: got ld=%b want 1", ld_state);
        else n_pass++;
      end
    end
    fifofull = 0;
    n_checks++;
    if (full_cnt !== 2 || laf_cnt !== 1 || busy_bad !== 0 || !detect_add)
      $display("FAIL fifo_full_summary: got ffs=%0d laf=%0d busy_bad=%0d want 2/1/0", full_cnt, laf_cnt, busy_bad);
    else n_pass++;
    $display("txn fifo_full: ffs=%0d laf=%0d", full_cnt, laf_cnt);
  endtask

  task automatic test_soft_reset();
    din = 2'd0; pkt_valid = 1;
    tick(); tick();
    srst = 3'b001; pkt_valid = 0;
    tick();
    srst = 0;
    n_checks++;
    if (obs_v() !== 8'b1000_0000) $display("FAIL srst_selected: got %b want %b", obs_v(), 8'b1000_0000);
    else n_pass++;
    pkt_valid = 1;
    tick(); tick();
    srst = 3'b010;
    tick();
    srst = 0;
    n_checks++;
    if (obs_v() !== 8'b0010_0100) $display("FAIL srst_other_port: got %b want %b", obs_v(), 8'b0010_0100);
    else n_pass++;
    pkt_valid = 0;
    for (int k = 0; k < 20 && !detect_add; k++) tick();
    n_checks++;
    if (!detect_add || obs_v() !== exp_outs(m_st)) $display("FAIL srst_finish: got %b want %b", obs_v(), 8'b1000_0000);
    else n_pass++;
    $display("txn soft_reset: selected port aborts, other port ignored");
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      pkt_valid     = ($urandom_range(0, 9) < 7);
      din           = 2'($urandom_range(0, 3));
      fifofull      = ($urandom_range(0, 9) < 2);
      for (int p = 0; p < 3; p++) begin
        e[p]    = ($urandom_range(0, 9) < 8);
        srst[p] = ($urandom_range(0, 99) < 4);
      end
      parity_done   = ($urandom_range(0, 9) == 0);
      low_pkt_valid = ($urandom_range(0, 9) == 0);
      rst           = ($urandom_range(0, 99) < 2);
      if (rst) model_reset();
      tick();
      n_checks++;
      if (obs_v() !== exp_outs(m_st)) begin
        $display("FAIL random_cycle%0d: got %b want %b (state %s)", c, obs_v(), exp_outs(m_st), m_st.name());
        errs++;
      end else n_pass++;
`ifdef ROUTER_FSM_STATS_EN
      n_checks++;
      if (int'(pkt_cnt) !== m_pkt || int'(drop_cnt) !== m_drop) begin
        $display("FAIL random_cnt%0d: got pkt=%0d drop=%0d want pkt=%0d drop=%0d", c, pkt_cnt, drop_cnt, m_pkt, m_drop);
        errs++;
      end else n_pass++;
`endif
    end
    rst = 0;
    $display("txn random: 400 cycles, %0d mismatching cycles", errs);
  endtask

`ifdef ROUTER_FSM_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      din = 2'(p); e = 3'b111;
      for (int c = 0; c < 7; c++) begin
        pkt_valid = (c < 3);
        tick();
      end
    end
    pkt_valid = 1; din = 2'd3;
    tick();
    pkt_valid = 0;
    tick();
    n_checks++;
    if (pkt_cnt !== 4'd2 || drop_cnt !== 4'd1) $display("FAIL stats_counts: got pkt=%0d drop=%0d want 2/1", pkt_cnt, drop_cnt);
    else n_pass++;
    pkt_valid = 1; din = 2'd3;
    for (int c = 0; c < 20; c++) tick();
    pkt_valid = 0;
    n_checks++;
    if (drop_cnt !== 4'hF || int'(drop_cnt) !== m_drop) $display("FAIL stats_saturate: got drop=%0d want 15", drop_cnt);
    else n_pass++;
    $display("txn stats: pkt=%0d drop=%0d", pkt_cnt, drop_cnt);
  endtask
`endif

  initial begin
    idle_inputs();
    rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_packet();
    test_wait_empty();
    test_fifo_full();
    test_soft_reset();
    test_random();
    do_reset();
`ifdef ROUTER_FSM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
